// File: rtl/sr_cmd_sequencer_pkg.sv
// Shared state encoding and helpers for the SR latch command sequencer.
// Pure declarations: no latency, no backpressure.
package sr_cmd_sequencer_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_DRV_S = 2'd1,
    ST_DRV_R = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  function automatic logic is_drive(input state_t st);
    return (st == ST_DRV_S) || (st == ST_DRV_R);
  endfunction

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Request levels in, latch commands and status out.
// Level-based signalling: no latency of its own, no backpressure.
interface sr_cmd_sequencer_if;
  logic set_req;
  logic rst_req;
  logic S;
  logic R;
  logic en;
  logic busy;
  logic conflict;
  logic q_model;
  logic q_valid;

  modport master (
    output set_req, rst_req,
    input  S, R, en, busy, conflict, q_model, q_valid
  );

  modport slave (
    input  set_req, rst_req,
    output S, R, en, busy, conflict, q_model, q_valid
  );
endinterface

// File: rtl/sr_cmd_sequencer_edge_det.sv
// Rising-edge detector on a synchronous request level.
// Combinational pulse in the cycle the level first reads high; no backpressure.
module sr_cmd_sequencer_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= req;
    end
  end

  assign rise = req & ~prev;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns set/reset request edges into clean, non-overlapping S/R/en pulses for a gated SR latch.
// Latency: request edge at k -> pulse k+1..k+PULSE_W; requests arriving while busy wait in pend flags.
module sr_cmd_sequencer
  import sr_cmd_sequencer_pkg::*;
#(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned DEAD_T  = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sr_cmd_sequencer_if.slave    bus
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'(DEAD_T);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic set_rise;
  logic rst_rise;

  sr_cmd_sequencer_edge_det u_set_det (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.set_req),
    .rise  (set_rise)
  );

  sr_cmd_sequencer_edge_det u_rst_det (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.rst_req),
    .rise  (rst_rise)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             set_pend, set_pend_nxt;
  logic             rst_pend, rst_pend_nxt;
  logic             set_clr, rst_clr;
  logic             q_model_q, q_model_nxt;
  logic             q_valid_q, q_valid_nxt;
  logic             conflict_q;
  logic             s_q, r_q, en_q;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt > CNT_ONE) ? cnt - CNT_ONE : cnt;
    set_clr     = 1'b0;
    rst_clr     = 1'b0;
    q_model_nxt = q_model_q;
    q_valid_nxt = q_valid_q;

    case (state)
      ST_IDLE: begin
        // Reset wins; a request that would not change the latch is retired without a pulse.
        if (rst_pend) begin
          rst_clr = 1'b1;
          if (!(q_valid_q && !q_model_q)) begin
            state_nxt   = ST_DRV_R;
            cnt_nxt     = PULSE_LD;
            q_model_nxt = 1'b0;
            q_valid_nxt = 1'b1;
          end
        end else if (set_pend) begin
          set_clr = 1'b1;
          if (!(q_valid_q && q_model_q)) begin
            state_nxt   = ST_DRV_S;
            cnt_nxt     = PULSE_LD;
            q_model_nxt = 1'b1;
            q_valid_nxt = 1'b1;
          end
        end
      end
      ST_DRV_S, ST_DRV_R: begin
        if (cnt <= CNT_ONE) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = DEAD_LD;
        end
      end
      ST_DEAD: begin
        if (cnt <= CNT_ONE) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Simultaneous edges collapse to a reset; edges on an already-set flag merge into it.
    set_pend_nxt = (set_pend & ~set_clr) | (set_rise & ~rst_rise);
    rst_pend_nxt = (rst_pend & ~rst_clr) | rst_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      set_pend   <= 1'b0;
      rst_pend   <= 1'b0;
      q_model_q  <= 1'b0;
      q_valid_q  <= 1'b0;
      conflict_q <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      set_pend   <= set_pend_nxt;
      rst_pend   <= rst_pend_nxt;
      q_model_q  <= q_model_nxt;
      q_valid_q  <= q_valid_nxt;
      conflict_q <= set_rise & rst_rise;
      s_q        <= (state_nxt == ST_DRV_S);
      r_q        <= (state_nxt == ST_DRV_R);
      en_q       <= is_drive(state_nxt);
    end
  end

  assign bus.S        = s_q;
  assign bus.R        = r_q;
  assign bus.en       = en_q;
  assign bus.conflict = conflict_q;
  assign bus.q_model  = q_model_q;
  assign bus.q_valid  = q_valid_q;
  assign bus.busy     = (state != ST_IDLE) | set_pend | rst_pend;

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(s_q && r_q) && ((s_q || r_q) == en_q));

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Scoreboarded bench for sr_cmd_sequencer: expected output words queued with each stimulus.
// Word layout everywhere: {S, R, en, busy, conflict, q_model, q_valid}.
module tb_sr_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sr_cmd_sequencer_if ifa ();
  sr_cmd_sequencer_if ifb ();

  sr_cmd_sequencer #(.PULSE_W(2), .DEAD_T(1), .CNT_W(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  sr_cmd_sequencer #(.PULSE_W(3), .DEAD_T(2), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [6:0] sb_a[$];
  logic [6:0] sb_b[$];

  function automatic logic [6:0] obs_a();
    return {ifa.S, ifa.R, ifa.en, ifa.busy, ifa.conflict, ifa.q_model, ifa.q_valid};
  endfunction

  function automatic logic [6:0] obs_b();
    return {ifb.S, ifb.R, ifb.en, ifb.busy, ifb.conflict, ifb.q_model, ifb.q_valid};
  endfunction

  task automatic push(input bit use_b, input logic [6:0] w);
    if (use_b) sb_b.push_back(w);
    else       sb_a.push_back(w);
  endtask

  // One command from IDLE: pending cycle, pw drive cycles, dt dead cycles, back to idle.
  task automatic push_cmd(input bit use_b, input bit is_set, input bit qm0, input bit qv0,
                          input bit conf, input int pw, input int dt);
    push(use_b, {1'b0, 1'b0, 1'b0, 1'b1, conf, qm0, qv0});
    for (int i = 0; i < pw; i++) push(use_b, {is_set, ~is_set, 1'b1, 1'b1, 1'b0, is_set, 1'b1});
    for (int i = 0; i < dt; i++) push(use_b, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, is_set, 1'b1});
    push(use_b, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, is_set, 1'b1});
  endtask

  task automatic idle_clk();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((ifa.S && ifa.R) || ((ifa.S || ifa.R) !== ifa.en)) begin
        errors++;
        $display("FAIL invariant_a: S=%b R=%b en=%b", ifa.S, ifa.R, ifa.en);
      end
      checks++;
      if ((ifb.S && ifb.R) || ((ifb.S || ifb.R) !== ifb.en)) begin
        errors++;
        $display("FAIL invariant_b: S=%b R=%b en=%b", ifb.S, ifb.R, ifb.en);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.set_req = 1'b0; ifa.rst_req = 1'b0;
    ifb.set_req = 1'b0; ifb.rst_req = 1'b0;
    #3;
    checks++;
    if (obs_a() !== 7'b0) begin
      errors++; $display("FAIL reset_a: got %b want %b", obs_a(), 7'b0);
    end
    checks++;
    if (obs_b() !== 7'b0) begin
      errors++; $display("FAIL reset_b: got %b want %b", obs_b(), 7'b0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_clk();
    checks++;
    if (obs_a() !== 7'b0) begin
      errors++; $display("FAIL reset_release_a: got %b want %b", obs_a(), 7'b0);
    end
  endtask

  task automatic test_set_pulse();
    logic [6:0] exp;
    int n;
    ifa.set_req = 1'b1;
    push_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1);
    n = sb_a.size();
    for (int i = 0; i < n; i++) begin
      idle_clk();
      exp = sb_a.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++; $display("FAIL set_pulse cyc%0d: got %b want %b", i, obs_a(), exp);
      end
    end
    ifa.set_req = 1'b0;
    idle_clk();
  endtask

  task automatic test_conflict();
    logic [6:0] exp;
    int n;
    ifa.set_req = 1'b1;
    ifa.rst_req = 1'b1;
    push_cmd(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1);
    n = sb_a.size();
    for (int i = 0; i < n; i++) begin
      idle_clk();
      exp = sb_a.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++; $display("FAIL conflict cyc%0d: got %b want %b", i, obs_a(), exp);
      end
    end
    ifa.set_req = 1'b0;
    ifa.rst_req = 1'b0;
    idle_clk();
  endtask

  task automatic test_rst_during_set();
    logic [6:0] exp;
    int n;
    ifa.set_req = 1'b1;
    push(1'b0, 7'b0001001);
    push(1'b0, 7'b1011011);
    push(1'b0, 7'b1011011);
    push(1'b0, 7'b0001011);
    push(1'b0, 7'b0001011);
    push(1'b0, 7'b0111001);
    push(1'b0, 7'b0111001);
    push(1'b0, 7'b0001001);
    push(1'b0, 7'b0000001);
    n = sb_a.size();
    for (int i = 0; i < n; i++) begin
      idle_clk();
      if (i == 0) ifa.rst_req = 1'b1;
      exp = sb_a.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++; $display("FAIL rst_during_set cyc%0d: got %b want %b", i, obs_a(), exp);
      end
    end
    ifa.set_req = 1'b0;
    ifa.rst_req = 1'b0;
    idle_clk();
  endtask

  task automatic test_redundant();
    logic [6:0] exp;
    int n;
    ifa.rst_req = 1'b1;
    push(1'b0, 7'b0001001);
    push(1'b0, 7'b0000001);
    push_cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1);
    push(1'b0, 7'b0000011);
    push(1'b0, 7'b0001011);
    push(1'b0, 7'b0000011);
    push(1'b0, 7'b0000011);
    n = sb_a.size();
    for (int i = 0; i < n; i++) begin
      idle_clk();
      if (i == 1) begin ifa.rst_req = 1'b0; ifa.set_req = 1'b1; end
      if (i == 6) ifa.set_req = 1'b0;
      if (i == 7) ifa.set_req = 1'b1;
      exp = sb_a.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++; $display("FAIL redundant cyc%0d: got %b want %b", i, obs_a(), exp);
      end
    end
    ifa.set_req = 1'b0;
    idle_clk();
  endtask

  task automatic test_midpulse_reset();
    logic [6:0] exp;
    int n;
    ifa.rst_req = 1'b1;
    push_cmd(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1);
    push(1'b0, 7'b0001001);
    push(1'b0, 7'b1011011);
    n = sb_a.size();
    for (int i = 0; i < n; i++) begin
      idle_clk();
      if (i == 4) begin ifa.rst_req = 1'b0; ifa.set_req = 1'b1; end
      exp = sb_a.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++; $display("FAIL midpulse_pre cyc%0d: got %b want %b", i, obs_a(), exp);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a() !== 7'b0) begin
      errors++; $display("FAIL midpulse_async: got %b want %b", obs_a(), 7'b0);
    end
    ifa.set_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, 7'b0);
    n = sb_a.size();
    for (int i = 0; i < n; i++) begin
      idle_clk();
      exp = sb_a.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++; $display("FAIL midpulse_post cyc%0d: got %b want %b", i, obs_a(), exp);
      end
    end
  endtask

  task automatic test_held_level();
    logic [6:0] exp;
    int n;
    ifb.set_req = 1'b1;
    push_cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 2);
    for (int i = 0; i < 5; i++) push(1'b1, 7'b0000011);
    n = sb_b.size();
    for (int i = 0; i < n; i++) begin
      idle_clk();
      if (i == 9) ifb.set_req = 1'b0;
      exp = sb_b.pop_front();
      checks++;
      if (obs_b() !== exp) begin
        errors++; $display("FAIL held_level cyc%0d: got %b want %b", i, obs_b(), exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set_pulse();
    test_conflict();
    test_rst_during_set();
    test_redundant();
    test_midpulse_reset();
    test_held_level();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
